// File: rtl/snake_pkg.sv
// Shared snake game definitions: playfield limits, coordinate widths,
// food placement states and the LFSR feedback mask.
package snake_pkg;

    localparam int XW = 5;
    localparam int YW = 4;

    localparam logic [XW-1:0] DEF_X_MIN = 5'd1;
    localparam logic [XW-1:0] DEF_X_MAX = 5'd20;
    localparam logic [YW-1:0] DEF_Y_MIN = 4'd1;
    localparam logic [YW-1:0] DEF_Y_MAX = 4'd14;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        S_PLACED,
        S_DRAW,
        S_WAIT,
        S_SCAN,
        S_DONE
    } food_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; a nonzero seed keeps it off the
// all-zero lock-up state.
module lfsr16
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = LFSR_MASK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= SEED;
        else if (en)
            q <= {1'b0, q[15:1]} ^ (q[0] ? MASK : 16'h0000);
    end

endmodule

// File: rtl/food_placer.sv
// Detects the snake head eating the food and re-places the food on a
// random free cell, validated against one full body scan.
module food_placer
    import snake_pkg::*;
#(
    parameter logic [15:0]   SEED    = 16'hACE1,
    parameter logic [XW-1:0] FOOD_X0 = 5'd15,
    parameter logic [YW-1:0] FOOD_Y0 = 4'd5,
    parameter logic [XW-1:0] X_MIN   = DEF_X_MIN,
    parameter logic [XW-1:0] X_MAX   = DEF_X_MAX,
    parameter logic [YW-1:0] Y_MIN   = DEF_Y_MIN,
    parameter logic [YW-1:0] Y_MAX   = DEF_Y_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] i_pos_x,
    input  logic [YW-1:0] i_pos_y,
    input  logic          i_pos_first,
    input  logic          i_pos_last,
    input  logic          i_pos_valid,
    input  logic          i_full,
    output logic          o_eat,
    output logic [XW-1:0] o_food_x,
    output logic [YW-1:0] o_food_y,
    output logic          o_food_valid,
    output logic          o_busy
);

    food_state_t   r_state, w_state_nxt;
    logic [XW-1:0] r_cand_x, w_cand_x_nxt;
    logic [YW-1:0] r_cand_y, w_cand_y_nxt;
    logic [XW-1:0] r_food_x, w_food_x_nxt;
    logic [YW-1:0] r_food_y, w_food_y_nxt;
    logic          r_hit, w_hit_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_eat, w_eat_nxt;
    logic          r_busy, w_busy_nxt;

    logic [15:0]   w_lfsr;
    logic [XW-1:0] w_cx;
    logic [YW-1:0] w_cy;
    logic          w_unused_bits;
    logic          w_in_range;
    logic          w_head;
    logic          w_on_food;
    logic          w_on_cand;
    logic          w_any_hit;

    lfsr16 #(.SEED(SEED), .MASK(LFSR_MASK)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (w_lfsr)
    );

    assign w_cx          = w_lfsr[4:0];
    assign w_cy          = w_lfsr[11:8];
    assign w_unused_bits = ^{w_lfsr[15:12], w_lfsr[7:5]};
    assign w_in_range    = (w_cx >= X_MIN) && (w_cx <= X_MAX) &&
                           (w_cy >= Y_MIN) && (w_cy <= Y_MAX);
    assign w_head        = i_pos_valid && i_pos_first;
    assign w_on_food     = {i_pos_x, i_pos_y} == {r_food_x, r_food_y};
    assign w_on_cand     = {i_pos_x, i_pos_y} == {r_cand_x, r_cand_y};
    // hit is cleared on entry to WAIT, so this also serves the head beat
    assign w_any_hit     = r_hit || w_on_cand;

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_x_nxt = r_cand_x;
        w_cand_y_nxt = r_cand_y;
        w_food_x_nxt = r_food_x;
        w_food_y_nxt = r_food_y;
        w_hit_nxt    = r_hit;
        w_valid_nxt  = r_valid;
        w_eat_nxt    = 1'b0;
        unique case (r_state)
            S_PLACED: begin
                if (w_head && w_on_food) begin
                    w_eat_nxt   = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (i_full) begin
                    w_state_nxt = S_DONE;
                end else if (w_in_range) begin
                    w_cand_x_nxt = w_cx;
                    w_cand_y_nxt = w_cy;
                    w_hit_nxt    = 1'b0;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT, S_SCAN: begin
                if (i_full) begin
                    w_state_nxt = S_DONE;
                end else if (i_pos_valid &&
                             (r_state == S_SCAN || i_pos_first)) begin
                    if (!i_pos_last) begin
                        w_hit_nxt   = w_any_hit;
                        w_state_nxt = S_SCAN;
                    end else if (w_any_hit) begin
                        w_state_nxt = S_DRAW;
                    end else begin
                        w_food_x_nxt = r_cand_x;
                        w_food_y_nxt = r_cand_y;
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = S_PLACED;
                    end
                end
            end
            S_DONE: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_PLACED;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_DRAW) ||
                     (w_state_nxt == S_WAIT) ||
                     (w_state_nxt == S_SCAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_PLACED;
            r_cand_x <= '0;
            r_cand_y <= '0;
            r_food_x <= FOOD_X0;
            r_food_y <= FOOD_Y0;
            r_hit    <= 1'b0;
            r_valid  <= 1'b1;
            r_eat    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cand_x <= w_cand_x_nxt;
            r_cand_y <= w_cand_y_nxt;
            r_food_x <= w_food_x_nxt;
            r_food_y <= w_food_y_nxt;
            r_hit    <= w_hit_nxt;
            r_valid  <= w_valid_nxt;
            r_eat    <= w_eat_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign o_eat        = r_eat;
    assign o_food_x     = r_food_x;
    assign o_food_y     = r_food_y;
    assign o_food_valid = r_valid;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer with an independent LFSR reference
// used to predict the placed food cell.
module tb_food_placer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] i_pos_x = '0;
    logic [3:0] i_pos_y = '0;
    logic       i_pos_first = 1'b0;
    logic       i_pos_last = 1'b0;
    logic       i_pos_valid = 1'b0;
    logic       i_full = 1'b0;
    logic       o_eat;
    logic [4:0] o_food_x;
    logic [3:0] o_food_y;
    logic       o_food_valid;
    logic       o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic [4:0]  f_x;
    logic [3:0]  f_y;

    always #5 clk = ~clk;

    food_placer dut (
        .clk          (clk),
        .rst          (rst),
        .i_pos_x      (i_pos_x),
        .i_pos_y      (i_pos_y),
        .i_pos_first  (i_pos_first),
        .i_pos_last   (i_pos_last),
        .i_pos_valid  (i_pos_valid),
        .i_full       (i_full),
        .o_eat        (o_eat),
        .o_food_x     (o_food_x),
        .o_food_y     (o_food_y),
        .o_food_valid (o_food_valid),
        .o_busy       (o_busy)
    );

    function automatic logic [15:0] m_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= m_next(m_lfsr);
    end

    task automatic first_cand(input logic [15:0] v, output logic [4:0] x,
                              output logic [3:0] y, output int steps);
        steps = 0;
        x = v[4:0];
        y = v[11:8];
        while (!(x >= 1 && x <= 20 && y >= 1 && y <= 14) && steps < 500) begin
            v = m_next(v);
            steps++;
            x = v[4:0];
            y = v[11:8];
        end
    endtask

    task automatic beat(input logic [4:0] x, input logic [3:0] y,
                        input logic f, input logic l);
        i_pos_x = x;
        i_pos_y = y;
        i_pos_first = f;
        i_pos_last = l;
        i_pos_valid = 1'b1;
        @(posedge clk);
        #1;
        i_pos_valid = 1'b0;
        i_pos_first = 1'b0;
        i_pos_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({o_eat, o_food_valid, o_busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_flags got=%b exp=010",
                     {o_eat, o_food_valid, o_busy});
        end
        n_cmp++;
        if ({o_food_x, o_food_y} !== {5'd15, 4'd5}) begin
            n_bad++;
            $display("FAIL reset_food got=(%0d,%0d) exp=(15,5)",
                     o_food_x, o_food_y);
        end
    endtask

    task automatic test_no_eat();
        beat(5'd14, 4'd5, 1'b1, 1'b0);
        n_cmp++;
        if (o_eat !== 1'b0) begin
            n_bad++;
            $display("FAIL no_eat_head got=%b exp=0", o_eat);
        end
        beat(5'd15, 4'd5, 1'b0, 1'b1);
        n_cmp++;
        if (o_eat !== 1'b0) begin
            n_bad++;
            $display("FAIL no_eat_body got=%b exp=0", o_eat);
        end
        idle(1);
        n_cmp++;
        if ({o_food_x, o_food_y, o_food_valid, o_busy} !==
            {5'd15, 4'd5, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL no_eat_food got=(%0d,%0d) v=%b b=%b exp=(15,5) v=1 b=0",
                     o_food_x, o_food_y, o_food_valid, o_busy);
        end
    endtask

    task automatic test_eat();
        logic [4:0] cx;
        logic [3:0] cy;
        int st;
        beat(5'd15, 4'd5, 1'b1, 1'b0);
        n_cmp++;
        if ({o_eat, o_food_valid, o_busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL eat_pulse got=%b exp=101",
                     {o_eat, o_food_valid, o_busy});
        end
        first_cand(m_lfsr, cx, cy, st);
        beat(5'd15, 4'd4, 1'b0, 1'b0);
        n_cmp++;
        if (o_eat !== 1'b0) begin
            n_bad++;
            $display("FAIL eat_once got=%b exp=0", o_eat);
        end
        beat(5'd15, 4'd3, 1'b0, 1'b1);
        idle(st + 3);
        beat(5'd3, 4'd0, 1'b1, 1'b0);
        beat(5'd4, 4'd0, 1'b0, 1'b0);
        n_cmp++;
        if ({o_food_valid, o_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL eat_scan got=%b exp=01", {o_food_valid, o_busy});
        end
        beat(5'd5, 4'd0, 1'b0, 1'b1);
        n_cmp++;
        if ({o_food_x, o_food_y, o_food_valid, o_busy} !==
            {cx, cy, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL place_first got=(%0d,%0d) v=%b b=%b exp=(%0d,%0d) v=1 b=0",
                     o_food_x, o_food_y, o_food_valid, o_busy, cx, cy);
        end
        f_x = cx;
        f_y = cy;
    endtask

    task automatic test_reject();
        logic [4:0] c2x, c3x;
        logic [3:0] c2y, c3y;
        int st;
        beat(f_x, f_y, 1'b1, 1'b0);
        n_cmp++;
        if (o_eat !== 1'b1) begin
            n_bad++;
            $display("FAIL rej_eat got=%b exp=1", o_eat);
        end
        first_cand(m_lfsr, c2x, c2y, st);
        beat(5'd0, 4'd0, 1'b0, 1'b1);
        idle(st + 3);
        beat(5'd0, 4'd0, 1'b1, 1'b0);
        beat(c2x, c2y, 1'b0, 1'b0);
        beat(5'd1, 4'd0, 1'b0, 1'b1);
        n_cmp++;
        if ({o_food_x, o_food_y, o_food_valid, o_busy} !==
            {f_x, f_y, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL rej_hold got=(%0d,%0d) v=%b b=%b exp=(%0d,%0d) v=0 b=1",
                     o_food_x, o_food_y, o_food_valid, o_busy, f_x, f_y);
        end
        first_cand(m_lfsr, c3x, c3y, st);
        idle(st + 3);
        beat(5'd2, 4'd0, 1'b1, 1'b0);
        beat(5'd3, 4'd0, 1'b0, 1'b1);
        n_cmp++;
        if ({o_food_x, o_food_y, o_food_valid, o_busy} !==
            {c3x, c3y, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rej_place got=(%0d,%0d) v=%b b=%b exp=(%0d,%0d) v=1 b=0",
                     o_food_x, o_food_y, o_food_valid, o_busy, c3x, c3y);
        end
        f_x = c3x;
        f_y = c3y;
    endtask

    task automatic test_single_beat();
        logic [4:0] cx;
        logic [3:0] cy;
        int st;
        beat(f_x, f_y, 1'b1, 1'b1);
        n_cmp++;
        if ({o_eat, o_busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL single_eat got=%b exp=11", {o_eat, o_busy});
        end
        first_cand(m_lfsr, cx, cy, st);
        idle(st + 3);
        beat(5'd2, 4'd0, 1'b1, 1'b1);
        n_cmp++;
        if ({o_food_x, o_food_y, o_food_valid, o_busy} !==
            {cx, cy, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL single_place got=(%0d,%0d) v=%b b=%b exp=(%0d,%0d) v=1 b=0",
                     o_food_x, o_food_y, o_food_valid, o_busy, cx, cy);
        end
        f_x = cx;
        f_y = cy;
        beat(f_x, f_y, 1'b1, 1'b1);
        n_cmp++;
        if (o_eat !== 1'b1) begin
            n_bad++;
            $display("FAIL single_eat2 got=%b exp=1", o_eat);
        end
        first_cand(m_lfsr, cx, cy, st);
        idle(st + 3);
        beat(cx, cy, 1'b1, 1'b1);
        n_cmp++;
        if ({o_food_valid, o_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL single_reject got=%b exp=01", {o_food_valid, o_busy});
        end
        first_cand(m_lfsr, cx, cy, st);
        idle(st + 3);
        beat(5'd2, 4'd0, 1'b1, 1'b1);
        n_cmp++;
        if ({o_food_x, o_food_y, o_food_valid, o_busy} !==
            {cx, cy, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL single_replace got=(%0d,%0d) v=%b b=%b exp=(%0d,%0d) v=1 b=0",
                     o_food_x, o_food_y, o_food_valid, o_busy, cx, cy);
        end
    endtask

    task automatic test_full();
        logic [4:0] cx;
        logic [3:0] cy;
        int st;
        do_reset();
        beat(5'd15, 4'd5, 1'b1, 1'b1);
        first_cand(m_lfsr, cx, cy, st);
        idle(st + 3);
        beat(5'd0, 4'd0, 1'b1, 1'b0);
        i_full = 1'b1;
        beat(5'd1, 4'd0, 1'b0, 1'b1);
        i_full = 1'b0;
        n_cmp++;
        if ({o_eat, o_food_valid, o_busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL full_done got=%b exp=000",
                     {o_eat, o_food_valid, o_busy});
        end
        idle(4);
        beat(5'd15, 4'd5, 1'b1, 1'b1);
        n_cmp++;
        if ({o_eat, o_food_valid, o_busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL full_stuck got=%b exp=000",
                     {o_eat, o_food_valid, o_busy});
        end
        do_reset();
        n_cmp++;
        if ({o_food_x, o_food_y, o_food_valid, o_busy} !==
            {5'd15, 4'd5, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL full_rst got=(%0d,%0d) v=%b b=%b exp=(15,5) v=1 b=0",
                     o_food_x, o_food_y, o_food_valid, o_busy);
        end
    endtask

    initial begin
        f_x = 5'd15;
        f_y = 4'd5;
        test_reset();
        test_no_eat();
        test_eat();
        test_reject();
        test_single_beat();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
